// File: rtl/sort_pkg.sv
// sort_pkg: shared types for the packet sorter datapath and its output checker
package sort_pkg;

    typedef enum logic {IDLE_S, IN_PKT_S} chk_state_t;

    typedef struct packed {
        logic order;
        logic frame;
        logic len;
    } pkt_flags_t;

    // Framing sideband of one Avalon-ST beat; data travels alongside at its own width
    typedef struct packed {
        logic sop;
        logic eop;
    } avst_beat_t;

endpackage

// File: rtl/avst_pipe_reg.sv
// avst_pipe_reg: one-slot ready/valid register for an Avalon-ST beat (data + SOP + EOP)
module avst_pipe_reg
    import sort_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] snk_data,
    input  logic              snk_sop,
    input  logic              snk_eop,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [DWIDTH-1:0] src_data,
    output logic              src_sop,
    output logic              src_eop,
    output logic              src_valid,
    input  logic              src_ready
);

    avst_beat_t ctl;

    // Slot may refill in the same cycle it drains, so full-rate streams see no bubbles
    assign snk_ready = !src_valid | src_ready;
    assign src_sop   = ctl.sop;
    assign src_eop   = ctl.eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_valid <= 1'b0;
            src_data  <= '0;
            ctl       <= '0;
        end else if (snk_valid && snk_ready) begin
            src_valid <= 1'b1;
            src_data  <= snk_data;
            ctl       <= '{sop: snk_sop, eop: snk_eop};
        end else if (src_ready) begin
            src_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sorted_pkt_checker.sv
// sorted_pkt_checker: forwards sorted Avalon-ST packets through one register slot and reports per-packet order/framing/length stats
module sorted_pkt_checker
    import sort_pkg::*;
#(
    parameter  int DWIDTH      = 16,
    parameter  int MAX_PKT_LEN = 250,
    parameter  int CWIDTH      = 16,
    localparam int LWIDTH      = $clog2(MAX_PKT_LEN + 2)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    input  logic              clr_i,
    output logic              pkt_done_o,
    output logic [LWIDTH-1:0] pkt_len_o,
    output logic [DWIDTH-1:0] pkt_min_o,
    output logic [DWIDTH-1:0] pkt_max_o,
    output logic              err_order_o,
    output logic              err_frame_o,
    output logic              err_len_o,
    output logic [CWIDTH-1:0] pkt_cnt_o,
    output logic [CWIDTH-1:0] err_cnt_o
);

    localparam logic [LWIDTH-1:0] LSAT = LWIDTH'(MAX_PKT_LEN + 1);

    chk_state_t        state, state_n;
    logic [LWIDTH-1:0] len, len_n, len_inc;
    logic [DWIDTH-1:0] mn, mn_n, mx, mx_n, prev, prev_n;
    pkt_flags_t        flg, flg_n;
    logic              accept, sop, eop;
    logic [DWIDTH-1:0] d;

    logic              a_v, b_v;
    logic [LWIDTH-1:0] a_len;
    logic [DWIDTH-1:0] a_min, a_max;
    pkt_flags_t        a_flg;

    logic              p_v, pn_v, r_v;
    logic [LWIDTH-1:0] p_len, pn_len, r_len;
    logic [DWIDTH-1:0] p_min, pn_min, r_min, p_max, pn_max, r_max;
    pkt_flags_t        p_flg, pn_flg, r_flg;

    avst_pipe_reg #(.DWIDTH(DWIDTH)) u_pipe (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .snk_data  (snk_data_i),
        .snk_sop   (snk_startofpacket_i),
        .snk_eop   (snk_endofpacket_i),
        .snk_valid (snk_valid_i),
        .snk_ready (snk_ready_o),
        .src_data  (src_data_o),
        .src_sop   (src_startofpacket_o),
        .src_eop   (src_endofpacket_o),
        .src_valid (src_valid_o),
        .src_ready (src_ready_i)
    );

    assign accept  = snk_valid_i & snk_ready_o;
    assign sop     = snk_startofpacket_i;
    assign eop     = snk_endofpacket_i;
    assign d       = snk_data_i;
    assign len_inc = (len == LSAT) ? LSAT : len + 1'b1;

    // a_*: packet completed by this beat; b_v: extra 1-word packet when SOP&EOP aborts an open packet
    always_comb begin
        state_n = state;
        len_n   = len;
        mn_n    = mn;
        mx_n    = mx;
        prev_n  = prev;
        flg_n   = flg;
        a_v     = 1'b0;
        b_v     = 1'b0;
        a_len   = len;
        a_min   = mn;
        a_max   = mx;
        a_flg   = flg;
        if (accept) begin
            if (state == IN_PKT_S && !sop) begin
                len_n       = len_inc;
                mn_n        = (d < mn) ? d : mn;
                mx_n        = (d > mx) ? d : mx;
                prev_n      = d;
                flg_n.order = flg.order | (d < prev);
                flg_n.len   = (len_inc == LSAT);
                state_n     = eop ? IDLE_S : IN_PKT_S;
                a_v         = eop;
                a_len       = len_n;
                a_min       = mn_n;
                a_max       = mx_n;
                a_flg       = flg_n;
            end else begin
                len_n   = LWIDTH'(1);
                mn_n    = d;
                mx_n    = d;
                prev_n  = d;
                flg_n   = '{order: 1'b0, frame: !sop, len: 1'b0};
                state_n = eop ? IDLE_S : IN_PKT_S;
                if (state == IN_PKT_S) begin
                    a_v         = 1'b1;
                    a_flg.frame = 1'b1;
                    b_v         = eop;
                end else begin
                    a_v   = eop;
                    a_len = LWIDTH'(1);
                    a_min = d;
                    a_max = d;
                    a_flg = flg_n;
                end
            end
        end
    end

    // A double completion always follows a non-completing beat, so one pending slot never overflows
    always_comb begin
        r_v    = p_v | a_v;
        r_len  = p_v ? p_len : a_len;
        r_min  = p_v ? p_min : a_min;
        r_max  = p_v ? p_max : a_max;
        r_flg  = p_v ? p_flg : a_flg;
        pn_v   = p_v ? a_v : b_v;
        pn_len = p_v ? a_len : LWIDTH'(1);
        pn_min = p_v ? a_min : d;
        pn_max = p_v ? a_max : d;
        pn_flg = p_v ? a_flg : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE_S;
            len   <= '0;
            mn    <= '0;
            mx    <= '0;
            prev  <= '0;
            flg   <= '0;
            p_v   <= 1'b0;
            p_len <= '0;
            p_min <= '0;
            p_max <= '0;
            p_flg <= '0;
        end else begin
            state <= state_n;
            len   <= len_n;
            mn    <= mn_n;
            mx    <= mx_n;
            prev  <= prev_n;
            flg   <= flg_n;
            p_v   <= pn_v;
            p_len <= pn_len;
            p_min <= pn_min;
            p_max <= pn_max;
            p_flg <= pn_flg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_done_o  <= 1'b0;
            pkt_len_o   <= '0;
            pkt_min_o   <= '0;
            pkt_max_o   <= '0;
            err_order_o <= 1'b0;
            err_frame_o <= 1'b0;
            err_len_o   <= 1'b0;
            pkt_cnt_o   <= '0;
            err_cnt_o   <= '0;
        end else begin
            pkt_done_o <= r_v;
            if (r_v) begin
                pkt_len_o   <= r_len;
                pkt_min_o   <= r_min;
                pkt_max_o   <= r_max;
                err_order_o <= r_flg.order;
                err_frame_o <= r_flg.frame;
                err_len_o   <= r_flg.len;
            end
            if (clr_i) begin
                pkt_cnt_o <= '0;
                err_cnt_o <= '0;
            end else if (r_v) begin
                pkt_cnt_o <= (pkt_cnt_o == '1) ? pkt_cnt_o : pkt_cnt_o + 1'b1;
                if (|r_flg)
                    err_cnt_o <= (err_cnt_o == '1) ? err_cnt_o : err_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sorted_pkt_checker.sv
// tb_sorted_pkt_checker: directed packets checked against a packet-level model every cycle plus literal report checks
module tb_sorted_pkt_checker;

    localparam int DW = 16;
    localparam int ML = 250;
    localparam int CW = 16;
    localparam int LW = $clog2(ML + 2);

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b1;
    logic [DW-1:0] snk_data_i = '0;
    logic          snk_startofpacket_i = 1'b0;
    logic          snk_endofpacket_i = 1'b0;
    logic          snk_valid_i = 1'b0;
    logic          snk_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o;
    logic          src_endofpacket_o;
    logic          src_valid_o;
    logic          src_ready_i = 1'b1;
    logic          clr_i = 1'b0;
    logic          pkt_done_o;
    logic [LW-1:0] pkt_len_o;
    logic [DW-1:0] pkt_min_o;
    logic [DW-1:0] pkt_max_o;
    logic          err_order_o;
    logic          err_frame_o;
    logic          err_len_o;
    logic [CW-1:0] pkt_cnt_o;
    logic [CW-1:0] err_cnt_o;

    sorted_pkt_checker #(.DWIDTH(DW), .MAX_PKT_LEN(ML), .CWIDTH(CW)) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i),
        .clr_i               (clr_i),
        .pkt_done_o          (pkt_done_o),
        .pkt_len_o           (pkt_len_o),
        .pkt_min_o           (pkt_min_o),
        .pkt_max_o           (pkt_max_o),
        .err_order_o         (err_order_o),
        .err_frame_o         (err_frame_o),
        .err_len_o           (err_len_o),
        .pkt_cnt_o           (pkt_cnt_o),
        .err_cnt_o           (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int len;
        int mn;
        int mx;
        bit o;
        bit f;
        bit l;
    } rep_t;

    typedef struct {
        int d;
        bit s;
        bit e;
    } beat_t;

    int    n_cmp = 0;
    int    n_fail = 0;
    bit    rnd_rdy = 0;
    rep_t  rep_q[$];
    rep_t  last;
    beat_t fwd_q[$];
    beat_t bt;
    int    words[$];
    bit    in_pkt, frm, clr_prev, dn;
    int    cnt, ecnt;
    int    cap_len, cap_min, cap_max, cap_cnt, cap_ecnt;
    bit    cap_o, cap_f, cap_l;

    function automatic void check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void reset_model();
        rep_q.delete();
        fwd_q.delete();
        words.delete();
        last = '{default: 0};
        in_pkt = 0;
        frm = 0;
        clr_prev = 0;
        cnt = 0;
        ecnt = 0;
    endfunction

    // Stats computed from the whole word list of a finished packet
    function automatic void finish_pkt();
        rep_t r;
        int   mn, mx;
        bit   o;
        mn = words[0];
        mx = words[0];
        o  = 0;
        foreach (words[i]) begin
            if (words[i] < mn) mn = words[i];
            if (words[i] > mx) mx = words[i];
            if (i > 0 && words[i] < words[i-1]) o = 1;
        end
        r.len = (words.size() > ML) ? ML + 1 : words.size();
        r.mn  = mn;
        r.mx  = mx;
        r.o   = o;
        r.f   = frm;
        r.l   = words.size() > ML;
        rep_q.push_back(r);
    endfunction

    function automatic void model_beat(input int d, input bit s, input bit e);
        if (!in_pkt) begin
            words = {d};
            frm = !s;
            if (e) finish_pkt();
            else in_pkt = 1;
        end else if (s) begin
            frm = 1;
            finish_pkt();
            words = {d};
            frm = 0;
            if (e) begin
                finish_pkt();
                in_pkt = 0;
            end
        end else begin
            words.push_back(d);
            if (e) begin
                finish_pkt();
                in_pkt = 0;
            end
        end
    endfunction

    // Inputs change at posedge+2 and are stable here; compare, then advance the model past the next edge
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            check("rst_outputs_zero", |{src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o,
                  pkt_done_o, pkt_len_o, pkt_min_o, pkt_max_o, err_order_o, err_frame_o, err_len_o,
                  pkt_cnt_o, err_cnt_o}, 0);
            check("rst_snk_ready", snk_ready_o, 1);
            reset_model();
        end else begin
            dn = rep_q.size() != 0;
            if (dn) last = rep_q.pop_front();
            if (clr_prev) begin
                cnt = 0;
                ecnt = 0;
            end else if (dn) begin
                cnt = (cnt == 65535) ? cnt : cnt + 1;
                if (last.o || last.f || last.l) ecnt = (ecnt == 65535) ? ecnt : ecnt + 1;
            end
            check("pkt_done", pkt_done_o, dn);
            check("pkt_len", pkt_len_o, last.len);
            check("pkt_min", pkt_min_o, last.mn);
            check("pkt_max", pkt_max_o, last.mx);
            check("err_order", err_order_o, last.o);
            check("err_frame", err_frame_o, last.f);
            check("err_len", err_len_o, last.l);
            check("pkt_cnt", pkt_cnt_o, cnt);
            check("err_cnt", err_cnt_o, ecnt);
            check("snk_ready", snk_ready_o, fwd_q.size() == 0 || src_ready_i);
            check("src_valid", src_valid_o, fwd_q.size() != 0);
            if (fwd_q.size() != 0) begin
                check("src_data", src_data_o, fwd_q[0].d);
                check("src_sop", src_startofpacket_o, fwd_q[0].s);
                check("src_eop", src_endofpacket_o, fwd_q[0].e);
                if (src_ready_i) void'(fwd_q.pop_front());
            end
            if (snk_valid_i && snk_ready_o) begin
                bt = '{d: int'(snk_data_i), s: snk_startofpacket_i, e: snk_endofpacket_i};
                fwd_q.push_back(bt);
                model_beat(bt.d, bt.s, bt.e);
            end
            clr_prev = clr_i;
        end
    end

    always @(posedge clk_i) begin
        if (rnd_rdy) begin
            #1;
            src_ready_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic sync();
        @(posedge clk_i);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 right after the edge that accepted the beat
    task automatic send(input int d, input bit s, input bit e);
        bit ok;
        ok = 0;
        snk_valid_i = 1'b1;
        snk_data_i = DW'(d);
        snk_startofpacket_i = s;
        snk_endofpacket_i = e;
        for (int k = 0; k < 200 && !ok; k++) begin
            #1;
            ok = snk_ready_o;
            @(posedge clk_i);
            #2;
        end
        if (!ok) check("send_timeout", 0, 1);
        snk_valid_i = 1'b0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i = 1'b0;
    endtask

    task automatic send_pkt(input int w[$]);
        foreach (w[i]) send(w[i], i == 0, i == w.size() - 1);
    endtask

    task automatic wait_rep();
        bit got;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk_i);
            #1;
            got = pkt_done_o;
        end
        if (!got) check("report_timeout", 0, 1);
        cap_len = pkt_len_o;
        cap_min = pkt_min_o;
        cap_max = pkt_max_o;
        cap_o = err_order_o;
        cap_f = err_frame_o;
        cap_l = err_len_o;
        cap_cnt = pkt_cnt_o;
        cap_ecnt = err_cnt_o;
        sync();
    endtask

    task automatic expect_rep(input string nm, input int len, input int mn, input int mx,
                              input bit o, input bit f, input bit l, input int c, input int ec);
        wait_rep();
        check({nm, "_len"}, cap_len, len);
        check({nm, "_min"}, cap_min, mn);
        check({nm, "_max"}, cap_max, mx);
        check({nm, "_flags"}, {cap_o, cap_f, cap_l}, {o, f, l});
        check({nm, "_cnt"}, cap_cnt, c);
        check({nm, "_ecnt"}, cap_ecnt, ec);
    endtask

    initial begin
        int q[$];
        int v, n;
        #1 rst_n_i = 1'b0;
        #1;
        check("reset_ready", snk_ready_o, 1);
        check("reset_cnt", pkt_cnt_o, 0);
        repeat (3) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        sync();

        send_pkt('{3, 5, 5, 9});
        expect_rep("t1", 4, 3, 9, 0, 0, 0, 1, 0);

        send_pkt('{7, 2, 8});
        expect_rep("t2", 3, 2, 8, 1, 0, 0, 2, 1);

        send(6, 0, 0);
        send(7, 0, 1);
        expect_rep("t3_nosop", 2, 6, 7, 0, 1, 0, 3, 2);

        send(10, 1, 0);
        send(11, 0, 0);
        send(12, 1, 0);
        expect_rep("t3_midsop", 2, 10, 11, 0, 1, 0, 4, 3);
        send(13, 0, 1);
        expect_rep("t3_restart", 2, 12, 13, 0, 0, 0, 5, 3);

        send(20, 1, 0);
        send(21, 0, 0);
        send(22, 1, 1);
        expect_rep("t3_abort", 2, 20, 21, 0, 1, 0, 6, 4);
        expect_rep("t3_oneword", 1, 22, 22, 0, 0, 0, 7, 4);

        q.delete();
        for (int i = 0; i < ML; i++) q.push_back(i);
        send_pkt(q);
        expect_rep("t4_maxlen", ML, 0, ML - 1, 0, 0, 0, 8, 4);
        q.push_back(ML);
        send_pkt(q);
        expect_rep("t4_overlen", ML + 1, 0, ML, 0, 0, 1, 9, 5);
        send_pkt('{4});
        expect_rep("t4_single", 1, 4, 4, 0, 0, 0, 10, 5);

        clr_i = 1'b1;
        sync();
        clr_i = 1'b0;
        #1;
        check("t5_clr_cnt", pkt_cnt_o, 0);
        check("t5_clr_ecnt", err_cnt_o, 0);
        sync();
        rnd_rdy = 1;
        for (int p = 0; p < 20; p++) begin
            q.delete();
            n = $urandom_range(1, 5);
            v = $urandom_range(0, 100);
            for (int i = 0; i < n; i++) begin
                q.push_back(v);
                v += $urandom_range(0, 3);
            end
            send_pkt(q);
        end
        rnd_rdy = 0;
        #2 src_ready_i = 1'b1;
        repeat (6) sync();
        check("t5_pkt_cnt", pkt_cnt_o, 20);
        check("t5_err_cnt", err_cnt_o, 0);

        send(30, 1, 0);
        send(31, 0, 0);
        rst_n_i = 1'b0;
        #1;
        check("t6_async_valid", src_valid_o, 0);
        check("t6_async_cnt", pkt_cnt_o, 0);
        check("t6_async_len", pkt_len_o, 0);
        sync();
        rst_n_i = 1'b1;
        sync();
        send_pkt('{40, 41});
        clr_i = 1'b1;
        #1;
        check("t6_done_with_clr", pkt_done_o, 1);
        check("t6_cnt_before_clr", pkt_cnt_o, 1);
        sync();
        clr_i = 1'b0;
        #1;
        check("t6_clr_cnt", pkt_cnt_o, 0);
        check("t6_clr_ecnt", err_cnt_o, 0);
        check("t6_len_kept", pkt_len_o, 2);
        check("t6_max_kept", pkt_max_o, 41);

        repeat (4) sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
